// File: rtl/eth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : eth_pkg                                                |
// | Description : Shared Ethernet constants and types for the CRC32      |
// |               generator/checker pair.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  localparam int ETH_MIN_LEN = 64;
  localparam int ETH_MAX_LEN = 1518;

  localparam int BYTE_W    = 8;
  // FCS length in bytes, which is also the depth of the RX delay line
  localparam int DLY_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_rx_fcs_check_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : eth_rx_fcs_check_if                                    |
// | Description : Byte stream with frame delimiters, no backpressure.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface eth_rx_fcs_check_if;
  import eth_pkg::*;

  logic              valid;
  logic [BYTE_W-1:0] data;
  logic              sof;
  logic              eof;

  modport master (output valid, data, sof, eof);
  modport slave  (input  valid, data, sof, eof);

endinterface
`default_nettype wire

// File: rtl/crc32_byte_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : crc32_byte_step                                        |
// | Description : One byte of reflected CRC32, LSB first, 8 unrolled     |
// |               serial steps. Shared by the TX generator and RX check. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module crc32_byte_step
  import eth_pkg::*;
(
  input  logic [31:0]       crc,
  input  logic [BYTE_W-1:0] data,
  output logic [31:0]       next_crc
);

  logic [31:0] acc;

  // Fold the byte in bit by bit, bit0 first as it appears on the wire
  always_comb begin
    acc = crc;
    for (int i = 0; i < BYTE_W; i++) begin
      if (acc[0] ^ data[i]) acc = (acc >> 1) ^ CRC32_POLY_REFL;
      else                  acc = acc >> 1;
    end
    next_crc = acc;
  end

endmodule
`default_nettype wire

// File: rtl/eth_rx_fcs_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : eth_rx_fcs_check                                       |
// | Description : RX Ethernet FCS checker. Forwards payload with the FCS |
// |               stripped and reports CRC/length/abort status.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int MAX_LEN = ETH_MAX_LEN,
  parameter int LEN_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  eth_rx_fcs_check_if.slave         in_stream,
  eth_rx_fcs_check_if.master        out_stream,
  output logic                      frame_done,
  output logic                      frame_ok,
  output logic                      crc_err,
  output logic                      len_err,
  output logic                      frame_abort,
  output logic [LEN_W-1:0]          frame_len
);

  rx_state_t                           state, state_nxt;
  logic [31:0]                         crc_q, crc_base, crc_nxt;
  logic [LEN_W-1:0]                    len_q, len_base, len_nxt;
  logic [DLY_DEPTH-1:0][BYTE_W-1:0]    dline;
  logic [2:0]                          fill, fill_base;
  logic                                first_pend, first_base;
  logic                                start, accept, restart, finish, emit, len_bad;

  crc32_byte_step u_crc_step (
    .crc      (crc_base),
    .data     (in_stream.data),
    .next_crc (crc_nxt)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus per-beat decode; a sof beat restarts every per-frame accumulator
  always_comb begin
    state_nxt  = state;
    start      = in_stream.valid && in_stream.sof;
    accept     = in_stream.valid && (in_stream.sof || state == RECV);
    restart    = start && (state == RECV);
    finish     = accept && in_stream.eof;
    crc_base   = start ? CRC32_INIT : crc_q;
    len_base   = start ? '0 : len_q;
    fill_base  = start ? 3'd0 : fill;
    first_base = start ? 1'b1 : first_pend;
    len_nxt    = (&len_base) ? len_base : len_base + LEN_W'(1);
    emit       = accept && (fill_base == 3'(DLY_DEPTH));
    len_bad    = (len_nxt < LEN_W'(MIN_LEN)) || (len_nxt > LEN_W'(MAX_LEN));
    if (start)  state_nxt = RECV;
    if (finish) state_nxt = IDLE;
  end

  // Per-frame accumulators: CRC, length, delay line and first-byte flag
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q      <= CRC32_INIT;
      len_q      <= '0;
      fill       <= 3'd0;
      dline      <= '0;
      first_pend <= 1'b0;
    end else if (accept) begin
      crc_q      <= finish ? CRC32_INIT : crc_nxt;
      len_q      <= finish ? '0 : len_nxt;
      // On eof the four bytes still in the line are the FCS; dropping the fill discards them
      fill       <= finish ? 3'd0 :
                    (fill_base == 3'(DLY_DEPTH)) ? fill_base : fill_base + 3'd1;
      dline      <= {dline[DLY_DEPTH-2:0], in_stream.data};
      first_pend <= first_base && !emit;
    end
  end

  // Registered payload output: the oldest byte leaves once the line is full
  always_ff @(posedge clk) begin
    if (rst) begin
      out_stream.valid <= 1'b0;
      out_stream.data  <= '0;
      out_stream.sof   <= 1'b0;
      out_stream.eof   <= 1'b0;
    end else begin
      out_stream.valid <= emit;
      out_stream.data  <= emit ? dline[DLY_DEPTH-1] : '0;
      out_stream.sof   <= emit && first_base;
      out_stream.eof   <= emit && in_stream.eof;
    end
  end

  // Frame status; a completed frame on the same beat as a restart reports its own result
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      frame_abort <= 1'b0;
      frame_len   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (finish) begin
        frame_done  <= 1'b1;
        frame_abort <= 1'b0;
        crc_err     <= (crc_nxt != CRC32_RESIDUE);
        len_err     <= len_bad;
        frame_ok    <= (crc_nxt == CRC32_RESIDUE) && !len_bad;
        frame_len   <= len_nxt;
      end else if (restart) begin
        frame_done  <= 1'b1;
        frame_abort <= 1'b1;
        crc_err     <= 1'b0;
        len_err     <= 1'b0;
        frame_ok    <= 1'b0;
        frame_len   <= len_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_fcs_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_eth_rx_fcs_check                                    |
// | Description : Self-checking bench for eth_rx_fcs_check with a        |
// |               frame-level reference model.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_eth_rx_fcs_check;
  import eth_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_rx_fcs_check_if in_bus();
  eth_rx_fcs_check_if out_a();
  eth_rx_fcs_check_if out_b();

  logic        done_a, ok_a, crc_a, lenerr_a, abort_a;
  logic [15:0] len_a;
  logic        done_b, ok_b, crc_b, lenerr_b, abort_b;
  logic [15:0] len_b;

  // Default-parameter instance
  eth_rx_fcs_check dut_std (
    .clk(clk), .rst(rst), .in_stream(in_bus), .out_stream(out_a),
    .frame_done(done_a), .frame_ok(ok_a), .crc_err(crc_a), .len_err(lenerr_a),
    .frame_abort(abort_a), .frame_len(len_a)
  );

  // Same stream with MIN_LEN=1 so short frames can report frame_ok
  eth_rx_fcs_check #(.MIN_LEN(1), .MAX_LEN(ETH_MAX_LEN), .LEN_W(16)) dut_min1 (
    .clk(clk), .rst(rst), .in_stream(in_bus), .out_stream(out_b),
    .frame_done(done_b), .frame_ok(ok_b), .crc_err(crc_b), .len_err(lenerr_b),
    .frame_abort(abort_b), .frame_len(len_b)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] crc_tab [256];
  logic [9:0]  exp_pay[$], obs_pay[$];
  logic [19:0] exp_st[$], obs_st[$], exp_st1[$], obs_st1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Table-driven CRC over a whole byte list
  function automatic logic [31:0] crc_of(input bq_t f);
    logic [31:0] c = CRC32_INIT;
    foreach (f[i]) c = crc_tab[c[7:0] ^ f[i]] ^ (c >> 8);
    return c;
  endfunction

  // Status word {abort, ok, len_err, crc_err, len[15:0]} of a completed frame
  function automatic logic [19:0] stat_full(input bq_t f, input int min_len);
    int          n = f.size();
    logic        ce, le;
    logic [15:0] l;
    ce = (crc_of(f) != CRC32_RESIDUE);
    le = (n < min_len) || (n > ETH_MAX_LEN);
    l  = (n > 65535) ? 16'hFFFF : 16'(n);
    return {1'b0, ~(ce | le), le, ce, l};
  endfunction

  // kind 0: frame completes; 1: cut after k bytes by a new sof; 2: cut by reset
  task automatic model(input bq_t f, input int k, input int kind);
    for (int i = 0; i < k - 4; i++)
      exp_pay.push_back({(i == 0), (kind == 0) && (i == k - 5), f[i]});
    if (kind == 0) begin
      exp_st.push_back(stat_full(f, ETH_MIN_LEN));
      exp_st1.push_back(stat_full(f, 1));
    end else if (kind == 1) begin
      exp_st.push_back({4'b1000, 16'(k)});
      exp_st1.push_back({4'b1000, 16'(k)});
    end
  endtask

  function automatic bq_t make(input int n, input bit good);
    bq_t         f;
    logic [31:0] c;
    int          p;
    if (n < 4) begin
      for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      return f;
    end
    for (int i = 0; i < n - 4; i++) f.push_back(8'($urandom));
    c = ~crc_of(f);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    if (!good) begin
      p = $urandom_range(0, n - 1);
      f[p] = f[p] ^ (8'd1 << $urandom_range(0, 7));
    end
    return f;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put(input logic [7:0] d, input logic s, input logic e);
    in_bus.valid = 1'b1; in_bus.data = d; in_bus.sof = s; in_bus.eof = e;
    @(posedge clk); #1;
    in_bus.valid = 1'b0; in_bus.data = 8'h00; in_bus.sof = 1'b0; in_bus.eof = 1'b0;
  endtask

  // gm 0: back-to-back; 1: one idle between beats; 2: random 0..2 idles
  task automatic send(input bq_t f, input int k, input int gm);
    for (int i = 0; i < k; i++) begin
      if (gm == 1 && i > 0) idle(1);
      else if (gm == 2)     idle($urandom_range(0, 2));
      put(f[i], (i == 0), (i == f.size() - 1));
    end
  endtask

  task automatic verify(input string tag);
    idle(4);
    check({tag, "_pay_n"}, obs_pay.size(), exp_pay.size());
    while (obs_pay.size() > 0 && exp_pay.size() > 0)
      check({tag, "_pay"}, 32'(obs_pay.pop_front()), 32'(exp_pay.pop_front()));
    check({tag, "_st_n"}, obs_st.size(), exp_st.size());
    while (obs_st.size() > 0 && exp_st.size() > 0)
      check({tag, "_st"}, 32'(obs_st.pop_front()), 32'(exp_st.pop_front()));
    check({tag, "_st1_n"}, obs_st1.size(), exp_st1.size());
    while (obs_st1.size() > 0 && exp_st1.size() > 0)
      check({tag, "_st1"}, 32'(obs_st1.pop_front()), 32'(exp_st1.pop_front()));
    obs_pay.delete(); exp_pay.delete();
    obs_st.delete();  exp_st.delete();
    obs_st1.delete(); exp_st1.delete();
  endtask

  // Output monitor on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (out_a.valid) begin
        obs_pay.push_back({out_a.sof, out_a.eof, out_a.data});
        if (out_a.eof) check("eof_with_done", 32'(done_a), 32'd1);
      end
      if (done_a) obs_st.push_back({abort_a, ok_a, lenerr_a, crc_a, len_a});
      if (done_b) obs_st1.push_back({abort_b, ok_b, lenerr_b, crc_b, len_b});
    end
  end

  initial begin
    bq_t         f, g, t1, t2;
    logic [31:0] c;
    int          n, k, gm, sel;
    bit          prev_abort;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      crc_tab[i] = c;
    end

    in_bus.valid = 1'b0; in_bus.data = 8'h00; in_bus.sof = 1'b0; in_bus.eof = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_a.valid), 32'd0);
    check("rst_sof_eof", 32'({out_a.sof, out_a.eof}), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_len", 32'(len_a), 32'd0);
    check("rst_flags", 32'({ok_a, crc_a, lenerr_a, abort_a}), 32'd0);
    rst = 1'b0;
    idle(2);

    // "123456789" with its known FCS
    t1 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    send(t1, 13, 0); model(t1, 13, 0); verify("t1");

    t2 = t1;
    t2[3] = t2[3] ^ 8'h01;
    send(t2, 13, 0); model(t2, 13, 0); verify("t2_bitflip");

    f = make(60, 1);   send(f, 60, 0);   model(f, 60, 0);   verify("len60");
    f = make(1519, 1); send(f, 1519, 0); model(f, 1519, 0); verify("len1519");
    f = make(64, 1);   send(f, 64, 0);   model(f, 64, 0);   verify("len64");
    f = make(1518, 1); send(f, 1518, 0); model(f, 1518, 0); verify("len1518");
    f = make(5, 1);    send(f, 5, 0);    model(f, 5, 0);    verify("len5");
    f = make(1, 1);    send(f, 1, 0);    model(f, 1, 0);    verify("len1");

    f = make(64, 1); send(f, 64, 1); model(f, 64, 0); verify("gaps");

    f = make(64, 1); send(f, 20, 0); model(f, 20, 1);
    g = make(64, 1); send(g, 64, 0); model(g, 64, 0);
    verify("abort");

    f = make(100, 1); send(f, 30, 0); model(f, 30, 2);
    idle(2);
    verify("pre_rst");
    rst = 1'b1; idle(2); rst = 1'b0; idle(1);
    g = make(3, 1); send(g, 3, 0); model(g, 3, 0); verify("after_rst");

    prev_abort = 1'b0;
    for (int r = 0; r < 30; r++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       n = $urandom_range(1, 8);
        1:       n = $urandom_range(60, 70);
        2:       n = $urandom_range(5, 300);
        default: n = $urandom_range(1510, 1520);
      endcase
      if (prev_abort && n < 2) n = 2;
      f = make(n, ($urandom_range(0, 3) != 0));
      if (!prev_abort && $urandom_range(0, 2) == 0)
        put(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      gm = $urandom_range(0, 2);
      if (n >= 2 && $urandom_range(0, 5) == 0) begin
        k = $urandom_range(1, n - 1);
        send(f, k, gm); model(f, k, 1);
        prev_abort = 1'b1;
      end else begin
        send(f, n, gm); model(f, n, 0);
        prev_abort = 1'b0;
        verify("rand");
      end
    end
    f = make(64, 1); send(f, 64, 2); model(f, 64, 0); verify("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
